// File: rtl/switch_poll_pkg.sv
// Shared types and constants for the switch polling master and its debouncer.
package switch_poll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT_DATA,
    EVAL
  } state_t;

  localparam int DEFAULT_DATA_W = 18;
  localparam int TIMEOUT_CYCLES = 255;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/sample_debounce.sv
// Debounce filter: a value is accepted once STABLE_COUNT consecutive samples agree.
module sample_debounce
  import switch_poll_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int STABLE_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_strobe,
  output logic [DATA_W-1:0] sw_stable,
  output logic              sw_valid,
  output logic              sw_changed
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_COUNT);

  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] cand_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              accept;

  // Count saturates at STABLE_N so a long-held value never wraps and re-fires.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (sample == cand) begin
      cnt_next = (cnt >= STABLE_N) ? STABLE_N : cnt + 4'd1;
    end else begin
      cand_next = sample;
      cnt_next  = 4'd1;
    end
    accept = (cnt_next == STABLE_N) && ((cand_next != sw_stable) || !sw_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand       <= '0;
      cnt        <= '0;
      sw_stable  <= '0;
      sw_valid   <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (sample_strobe) begin
        cand <= cand_next;
        cnt  <= cnt_next;
        if (accept) begin
          sw_stable  <= cand_next;
          sw_valid   <= 1'b1;
          sw_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/switch_poll_controller.sv
// Avalon-MM master that periodically reads the switch PIO and feeds a debouncer.
module switch_poll_controller
  import switch_poll_pkg::*;
#(
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int TIMEOUT      = TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              poll_now,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] sw_stable,
  output logic              sw_valid,
  output logic              sw_changed,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int TMR_W = $clog2(POLL_DIV);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [TMR_W-1:0]  timer;
  logic [TO_W-1:0]   wait_cnt;
  logic              tick;
  logic              req;
  logic              pending;
  logic              consume;
  logic              capture;
  logic              timeout_set;
  logic [DATA_W-1:0] sample;
  logic              sample_strobe;
  logic              unused_hi;

  assign avm_address   = PIO_DATA_ADDR;
  assign tick          = enable && (timer == TMR_LAST);
  assign req           = tick || poll_now;
  assign consume       = (state == IDLE) && pending;
  assign sample_strobe = (state == EVAL);
  // Upper readdata bits carry nothing useful for the switch word.
  assign unused_hi     = ^avm_readdata[31:DATA_W];

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    timeout_set = 1'b0;
    case (state)
      IDLE: begin
        if (pending) state_next = READ;
      end
      READ: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            capture    = 1'b1;
            state_next = EVAL;
          end else begin
            state_next = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (avm_readdatavalid) begin
          capture    = 1'b1;
          state_next = EVAL;
        end else if (wait_cnt == TO_LAST) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end
      end
      EVAL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A request landing in the same cycle IDLE consumes pending refills it rather than overrunning.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      timer       <= '0;
      pending     <= 1'b0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state    <= state_next;
      avm_read <= (state_next == READ);
      if (!enable || (timer == TMR_LAST)) timer <= '0;
      else                                 timer <= timer + 1'b1;
      pending <= (pending && !consume) || req;
      if (req && pending && !consume) overrun <= 1'b1;
      wait_cnt <= (state == WAIT_DATA) ? wait_cnt + 1'b1 : '0;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) sample <= avm_readdata[DATA_W-1:0];
  end

  sample_debounce #(
    .DATA_W      (DATA_W),
    .STABLE_COUNT(STABLE_COUNT)
  ) u_deb (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_strobe(sample_strobe),
    .sw_stable    (sw_stable),
    .sw_valid     (sw_valid),
    .sw_changed   (sw_changed)
  );

endmodule

// File: tb/tb_switch_poll_controller.sv
// Directed bench for switch_poll_controller with a latency-1 PIO slave model.
module tb_switch_poll_controller;
  import switch_poll_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        poll_now = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [17:0] sw_stable;
  logic        sw_valid;
  logic        sw_changed;
  logic        timeout_err;
  logic        overrun;

  logic [17:0] sw_word = 18'h2A5A5;
  logic        rdv_en = 1'b1;
  logic        late_rdv = 1'b0;
  logic        acc_q;
  int          rd_acc_cnt = 0;
  int          chg_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          base;

  always #5 clk = ~clk;

  switch_poll_controller #(
    .POLL_DIV    (8),
    .STABLE_COUNT(3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .poll_now         (poll_now),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .sw_stable        (sw_stable),
    .sw_valid         (sw_valid),
    .sw_changed       (sw_changed),
    .timeout_err      (timeout_err),
    .overrun          (overrun)
  );

  // Slave: data returns one cycle after an accepted read; upper bits are junk.
  always @(posedge clk) begin
    acc_q = avm_read && !avm_waitrequest;
    if (acc_q) rd_acc_cnt++;
    #1;
    avm_readdatavalid = (acc_q && rdv_en) || late_rdv;
    avm_readdata      = {14'h3FFF, sw_word};
  end

  always @(negedge clk) begin
    if (sw_changed === 1'b1) chg_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_poll();
    poll_now = 1'b1;
    cyc(1);
    poll_now = 1'b0;
    cyc(8);
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", {30'd0, avm_address}, 32'd0);
    check("rst_stable", {14'd0, sw_stable}, 32'd0);
    check("rst_valid", {31'd0, sw_valid}, 32'd0);
    check("rst_changed", {31'd0, sw_changed}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);

    // Power-on acceptance via periodic polls: debounce updates land after P12, P20, P28.
    enable = 1'b1;
    cyc(24);
    check("pwr_valid_early", {31'd0, sw_valid}, 32'd0);
    cyc(8);
    check("pwr_valid", {31'd0, sw_valid}, 32'd1);
    check("pwr_stable", {14'd0, sw_stable}, 32'h2A5A5);
    check("pwr_pulses", chg_cnt, 32'd1);
    cyc(24);
    check("pwr_no_repulse", chg_cnt, 32'd1);
    enable = 1'b0;
    cyc(10);

    // Glitch rejection with explicit polls.
    sw_word = 18'h00001;
    do_poll(); do_poll(); do_poll();
    check("glitch_setup_stable", {14'd0, sw_stable}, 32'h00001);
    check("glitch_setup_pulses", chg_cnt, 32'd2);
    sw_word = 18'h3FFFF;
    do_poll();
    sw_word = 18'h00001;
    do_poll(); do_poll(); do_poll();
    check("glitch_stable", {14'd0, sw_stable}, 32'h00001);
    check("glitch_pulses", chg_cnt, 32'd2);

    // Waitrequest stall followed by a read that never returns data.
    base = rd_acc_cnt;
    avm_waitrequest = 1'b1;
    rdv_en = 1'b0;
    poll_now = 1'b1;
    cyc(1);
    poll_now = 1'b0;
    check("wr_read_lat", {31'd0, avm_read}, 32'd0);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      check("wr_read_held", {31'd0, avm_read}, 32'd1);
      check("wr_addr_held", {30'd0, avm_address}, 32'd0);
      cyc(1);
    end
    avm_waitrequest = 1'b0;
    cyc(1);
    check("wr_read_drop", {31'd0, avm_read}, 32'd0);
    check("wr_one_accept", rd_acc_cnt - base, 32'd1);
    cyc(199);
    check("to_not_yet", {31'd0, timeout_err}, 32'd0);
    cyc(60);
    check("to_set", {31'd0, timeout_err}, 32'd1);
    check("to_stable_kept", {14'd0, sw_stable}, 32'h00001);
    check("to_no_retry", rd_acc_cnt - base, 32'd1);
    check("to_state_idle", {30'd0, dut.state}, {30'd0, IDLE});

    // Overrun: read stalled across three ticks.
    rdv_en = 1'b1;
    avm_waitrequest = 1'b1;
    enable = 1'b1;
    cyc(20);
    check("ovr_stalled", {31'd0, avm_read}, 32'd1);
    check("ovr_not_yet", {31'd0, overrun}, 32'd0);
    cyc(6);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    avm_waitrequest = 1'b0;
    enable = 1'b0;
    cyc(20);

    // Coincident tick and poll_now produce one read.
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("rst2_overrun", {31'd0, overrun}, 32'd0);
    check("rst2_timeout", {31'd0, timeout_err}, 32'd0);
    base = rd_acc_cnt;
    enable = 1'b1;
    cyc(7);
    poll_now = 1'b1;
    cyc(1);
    poll_now = 1'b0;
    enable = 1'b0;
    cyc(12);
    check("coin_one_read", rd_acc_cnt - base, 32'd1);
    check("coin_no_overrun", {31'd0, overrun}, 32'd0);

    // Reset in WAIT_DATA, then a late readdatavalid.
    do_poll(); do_poll();
    check("mid_setup_valid", {31'd0, sw_valid}, 32'd1);
    check("mid_setup_stable", {14'd0, sw_stable}, 32'h00001);
    rdv_en = 1'b0;
    poll_now = 1'b1;
    cyc(1);
    poll_now = 1'b0;
    cyc(2);
    check("mid_in_wait", {30'd0, dut.state}, {30'd0, WAIT_DATA});
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    late_rdv = 1'b1;
    sw_word = 18'h15555;
    cyc(1);
    late_rdv = 1'b0;
    cyc(4);
    check("mid_read", {31'd0, avm_read}, 32'd0);
    check("mid_stable", {14'd0, sw_stable}, 32'd0);
    check("mid_valid", {31'd0, sw_valid}, 32'd0);
    check("mid_changed", {31'd0, sw_changed}, 32'd0);
    check("mid_timeout", {31'd0, timeout_err}, 32'd0);
    check("mid_overrun", {31'd0, overrun}, 32'd0);
    check("mid_cnt", {28'd0, dut.u_deb.cnt}, 32'd0);
    check("mid_state", {30'd0, dut.state}, {30'd0, IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
